// File: rtl/scroll_window_feeder.sv
// Message buffer, scroll divider and registered 6-glyph window for the HEX scroll display.
// Optional key debounce is built when SCROLL_DEBOUNCE_EN is defined.
module scroll_window_feeder #(
    parameter int MAX_LEN         = 16,
    parameter int STEP_CYCLES     = 20000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        key_add_n,
    input  logic        key_del_n,
    input  logic        key_clr_n,
    input  logic [4:0]  glyph_sel,
    input  logic        dir,
    input  logic        fast,
    input  logic        pause,
    output logic [29:0] window,
    output logic [4:0]  len,
    output logic        full,
    output logic        empty,
    output logic        step_pulse
);
    localparam int          CW      = $clog2(STEP_CYCLES);
    localparam logic [4:0]  MAXL    = 5'(MAX_LEN);
    localparam logic [CW-1:0] TN_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] TF_LAST = CW'(STEP_CYCLES / 4 - 1);

    // key bit order: 0 add, 1 del, 2 clr
    logic [2:0] s1_q, s2_q, acc_q, prv_q, press;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q  <= '1;
            s2_q  <= '1;
            prv_q <= '1;
        end else begin
            s1_q  <= {key_clr_n, key_del_n, key_add_n};
            s2_q  <= s1_q;
            prv_q <= acc_q;
        end
    end

`ifdef SCROLL_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] dcnt_q [3];

    // Level is accepted once it has differed for DEBOUNCE_CYCLES cycles and still differs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            acc_q <= '1;
            for (int k = 0; k < 3; k++) dcnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (s2_q[k] == acc_q[k]) begin
                    dcnt_q[k] <= '0;
                end else if (dcnt_q[k] == DW'(DEBOUNCE_CYCLES)) begin
                    acc_q[k]  <= s2_q[k];
                    dcnt_q[k] <= '0;
                end else begin
                    dcnt_q[k] <= dcnt_q[k] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) acc_q <= '1;
        else          acc_q <= s2_q;
    end
`endif

    assign press = prv_q & ~acc_q;

    logic [4:0]    buf_q [32];
    logic [4:0]    len_q, len_d, ptr_q, ptr_d, idx;
    logic [CW-1:0] cnt_q, cnt_d, t_last;
    logic [29:0]   win_q, win_d;
    logic          step_q, step_fire, full_q, empty_q, edit, wr_en;

    assign t_last = fast ? TF_LAST : TN_LAST;

    always_comb begin
        cnt_d     = cnt_q;
        step_fire = 1'b0;
        if (!pause) begin
            if (cnt_q > t_last) begin
                cnt_d = '0;
            end else if (cnt_q == t_last) begin
                cnt_d     = '0;
                step_fire = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Ring period is len+1, so the last valid pointer value equals len.
    always_comb begin
        len_d = len_q;
        ptr_d = ptr_q;
        edit  = 1'b0;
        wr_en = 1'b0;
        if (press[2]) begin
            edit  = 1'b1;
            len_d = '0;
        end else if (press[0] ^ press[1]) begin
            edit = 1'b1;
            if (press[0] && len_q < MAXL) begin
                len_d = len_q + 5'd1;
                wr_en = 1'b1;
            end else if (press[1] && len_q != 5'd0) begin
                len_d = len_q - 5'd1;
            end
        end
        if (edit) begin
            if (press[2] || ptr_q > len_d) ptr_d = '0;
        end else if (step_fire) begin
            if (dir) ptr_d = (ptr_q == len_q) ? 5'd0 : ptr_q + 5'd1;
            else     ptr_d = (ptr_q == 5'd0) ? len_q : ptr_q - 5'd1;
        end
    end

    always_comb begin
        idx   = ptr_q;
        win_d = '0;
        for (int k = 0; k < 6; k++) begin
            win_d = {win_d[24:0], (idx == len_q) ? 5'd0 : buf_q[idx]};
            idx   = (idx == len_q) ? 5'd0 : idx + 5'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 32; i++) buf_q[i] <= '0;
            len_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            win_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (wr_en) buf_q[len_q] <= glyph_sel;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            step_q  <= step_fire;
            win_q   <= win_d;
            full_q  <= (len_q == MAXL);
            empty_q <= (len_q == 5'd0);
        end
    end

    assign window     = win_q;
    assign len        = len_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign step_pulse = step_q;
endmodule

// File: doc/scroll_window_feeder.md
# scroll_window_feeder

Upstream feeder for the HEX scroll display. Holds a user-composed message of up to MAX_LEN glyph codes, entered with debounced KEY presses and SW glyph selection. It owns the step-rate divider and scroll pointer, and presents a registered 6-glyph window each cycle. The downstream glyph-to-segment stage decodes each 5-bit code onto HEX5..HEX0. Code 0 is blank.

## Interface
- MAX_LEN, default 16: message capacity in glyphs (2..31).
- STEP_CYCLES, default 20000000: clocks per scroll step in normal mode (≥8, multiple of 4).
- DEBOUNCE_CYCLES, default 1000000: stable-level clocks required to accept a key change.
- CLOCK_50  in  1: clock; all logic on its rising edge.
- RESET_N  in  1: reset; asynchronous, active-low.
- key_add_n  in  1: raw KEY[0], active-low; press appends glyph_sel.
- key_del_n  in  1: raw KEY[1], active-low; press removes last glyph.
- key_clr_n  in  1: raw KEY[2], active-low; press empties message.
- glyph_sel  in  5: glyph code to append (SW[4:0]).
- dir  in  1: 1 = scroll left (pointer increments), 0 = scroll right.
- fast  in  1: 1 = step period STEP_CYCLES/4.
- pause  in  1: 1 = freeze divider and pointer.
- window  out  30: [29:25] HEX5 (leftmost) … [4:0] HEX0.
- len  out  5: current glyph count.
- full, empty  out  1: len==MAX_LEN, len==0.
- step_pulse  out  1: one-cycle pulse on each scroll step.

## Operation
- Keys: each key passes through a 2-FF synchronizer and then the accepted-level logic (see Configuration). A press event is a 1→0 transition of the accepted level, giving one pulse per press.
- Edit priority within a cycle: clr > (add XOR del). If add and del are both pressed in the same cycle, neither takes effect.
- Add: if len<MAX_LEN, buf[len]←glyph_sel and len←len+1. When full, the add is ignored and buffer contents are unchanged.
- Del: if len>0, len←len−1. When empty, the del is ignored.
- Clr: len←0 and ptr←0. Buffer contents need not be erased.
- Scroll sequence: the virtual ring is buf[0..len−1] followed by one blank, with period P=len+1, and 0≤ptr<P.
- Window position k (k=0 is HEX5) shows index i_k = (ptr+k) mod P. Index len displays blank (0).
- i_k is computed as a chain: i_0=ptr, and i_k = (i_{k−1}==P−1) ? 0 : i_{k−1}+1. This chain handles P<6, where the ring repeats within the window.
- len==0 gives an all-blank window, and ptr is held at 0.
- After any edit, if ptr≥new P, then ptr←0.
- Divider: cnt counts 0..T−1, where T = fast ? STEP_CYCLES/4 : STEP_CYCLES. step_pulse fires at cnt==T−1 and cnt returns to 0.
  - Toggling fast while cnt≥new T forces cnt←0 with no pulse.
  - pause holds cnt and suppresses step_pulse.
- Step: with dir=1, ptr ← ptr==P−1 ? 0 : ptr+1. With dir=0, ptr ← ptr==0 ? P−1 : ptr−1.
- A step that coincides with an edit is dropped: step_pulse still asserts, but ptr follows the edit rule.

## Timing
- Reset values: window=0, len=0, full=0, empty=1, step_pulse=0, ptr=0, cnt=0. All synchronizer and debounce state is reset to released (1).
- Key to buffer/len/ptr update: 3 clocks after the first edge that samples the raw key low (no debounce), or 3+DEBOUNCE_CYCLES clocks (debounce).
- window, full and empty are registered and update 1 clock after buffer/len/ptr change.
- step_pulse is registered and coincides with the ptr update edge. window reflects the new ptr 1 clock later.
- Reset asserted mid-operation clears everything immediately. The first step after release occurs T clocks after release.

## Configuration
- SCROLL_DEBOUNCE_EN defined:
  - Each synchronized key drives a counter that restarts on any level mismatch.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive cycles of the new level.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- SCROLL_DEBOUNCE_EN undefined: the accepted level is the synchronized level, and the counters are not built.

## Test plan
Bench parameters: STEP_CYCLES=8, DEBOUNCE_CYCLES=4, MAX_LEN=4.
- Reset, then add glyphs 5,6,7 → len=3, window = {5,6,7,0,5,6}. Step with dir=1 → {6,7,0,5,6,7}.
- With 1 glyph (code 9), step repeatedly with dir=0 → window alternates {9,0,9,0,9,0} and {0,9,0,9,0,9}, with ptr cycling 0→1→0.
- Add 5 glyphs → len=4, full=1, and the fifth add is ignored. Del ×5 → len=0, empty=1, window all 0.
- Set ptr=3 (len=3), then del → ptr=0 on the same edge as len=2.
- With fast=1, step_pulse occurs every 2 clocks. pause=1 gives no pulses and a frozen window. Holding add and del low together changes nothing.
- With SCROLL_DEBOUNCE_EN, a 3-cycle low glitch on key_add_n gives no add. A 6-cycle low gives exactly one add, with len updating 7 clocks after the press is first sampled low.
